// File: rtl/sdram_bus_arbiter.sv
// Two-master round-robin arbiter in front of the SDRAM controller bus port.
// Holds a grant until the controller accepts it and steers in-order read returns back to their issuer.
module sdram_bus_arbiter #(
    parameter int AW    = 23,
    parameter int DW    = 16,
    parameter int BW    = DW / 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_read,
    input  logic          m0_write,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [BW-1:0] m0_byteenable,
    output logic          m0_ready,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_read,
    input  logic          m1_write,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [BW-1:0] m1_byteenable,
    output logic          m1_ready,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          s_read,
    output logic          s_write,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    output logic [BW-1:0] s_byteenable,
    input  logic          s_ready,
    input  logic          s_rvalid,
    input  logic [DW-1:0] s_rdata,
    output logic          rvalid_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          state_r, state_nxt_s;
    logic            owner_r, owner_nxt_s;
    logic            rr_ptr_r;
    logic [DEPTH-1:0] fifo_r;
    logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            rvalid_err_r;

    logic full_s, elg0_s, elg1_s;
    logic grant_id_s, grant_vld_s, accept_s;
    logic push_s, pop_s, head_s, nonempty_s;

    // The full flag comes from the registered count, so a same-cycle pop never unblocks a read.
    assign full_s     = (count_r == CW'(DEPTH));
    assign nonempty_s = (count_r != {CW{1'b0}});
    assign elg0_s     = (m0_read | m0_write) & ~(m0_read & full_s);
    assign elg1_s     = (m1_read | m1_write) & ~(m1_read & full_s);

    // Grant selection and lock state transitions
    always_comb begin
        grant_id_s  = 1'b0;
        grant_vld_s = 1'b0;
        state_nxt_s = state_r;
        owner_nxt_s = owner_r;
        case (state_r)
            ST_IDLE: begin
                if (elg0_s && elg1_s) begin
                    grant_id_s  = rr_ptr_r;
                    grant_vld_s = 1'b1;
                end else if (elg1_s) begin
                    grant_id_s  = 1'b1;
                    grant_vld_s = 1'b1;
                end else if (elg0_s) begin
                    grant_id_s  = 1'b0;
                    grant_vld_s = 1'b1;
                end else begin
                    grant_id_s  = 1'b0;
                    grant_vld_s = 1'b0;
                end
                if (grant_vld_s && !s_ready) begin
                    state_nxt_s = ST_LOCKED;
                    owner_nxt_s = grant_id_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                grant_id_s  = owner_r;
                grant_vld_s = owner_r ? elg1_s : elg0_s;
                if (grant_vld_s && s_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Command forwarding multiplexer toward the controller
    always_comb begin
        if (grant_id_s) begin
            s_addr       = m1_addr;
            s_wdata      = m1_wdata;
            s_byteenable = m1_byteenable;
            s_read       = grant_vld_s & m1_read;
            s_write      = grant_vld_s & m1_write;
        end else begin
            s_addr       = m0_addr;
            s_wdata      = m0_wdata;
            s_byteenable = m0_byteenable;
            s_read       = grant_vld_s & m0_read;
            s_write      = grant_vld_s & m0_write;
        end
    end

    assign accept_s  = grant_vld_s & s_ready;
    assign m0_ready  = accept_s & ~grant_id_s;
    assign m1_ready  = accept_s & grant_id_s;

    assign push_s    = s_read & s_ready;
    assign pop_s     = s_rvalid & nonempty_s;
    assign head_s    = fifo_r[rd_ptr_r];
    assign m0_rvalid = pop_s & ~head_s;
    assign m1_rvalid = pop_s & head_s;
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;
    assign rvalid_err = rvalid_err_r;

    // Arbitration state, lock owner and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            owner_r  <= 1'b0;
            rr_ptr_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            owner_r <= owner_nxt_s;
            if (accept_s) begin
                rr_ptr_r <= ~grant_id_s;
            end
        end
    end

    // Read-ID tracking FIFO and spurious-return flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_r       <= {DEPTH{1'b0}};
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            count_r      <= {CW{1'b0}};
            rvalid_err_r <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= grant_id_s;
                wr_ptr_r         <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (s_rvalid && !nonempty_s) begin
                rvalid_err_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_bus_arbiter.sv
// Self-checking bench for sdram_bus_arbiter: expected grants and read-return owners
// are queued as stimulus is driven and popped when the arbiter responds.
module tb_sdram_bus_arbiter;

    localparam int AW = 23;
    localparam int DW = 16;
    localparam int BW = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_read, m0_write, m0_ready, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic [BW-1:0] m0_byteenable;
    logic          m1_read, m1_write, m1_ready, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [BW-1:0] m1_byteenable;
    logic          s_read, s_write, s_ready, s_rvalid, rvalid_err;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic [BW-1:0] s_byteenable;

    int n_checks = 0;
    int n_fail   = 0;
    int grant_q[$];
    int rd_id_q[$];

    sdram_bus_arbiter #(.AW(AW), .DW(DW), .BW(BW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_byteenable(m0_byteenable), .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_byteenable(m1_byteenable), .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .s_read(s_read), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_byteenable(s_byteenable), .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .rvalid_err(rvalid_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_read = 1'b0; m0_write = 1'b0; m0_addr = '0; m0_wdata = '0; m0_byteenable = '0;
        m1_read = 1'b0; m1_write = 1'b0; m1_addr = '0; m1_wdata = '0; m1_byteenable = '0;
        s_ready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    endtask

    task automatic issue_read(input int id, input logic [AW-1:0] addr);
        if (id == 0) begin m0_read = 1'b1; m0_addr = addr; end
        else begin m1_read = 1'b1; m1_addr = addr; end
        s_ready = 1'b1;
        rd_id_q.push_back(id);
        @(negedge clk);
        check_eq("rd_ready", (id == 0) ? m0_ready : m1_ready, 1);
        check_eq("rd_s_read", s_read, 1);
        check_eq("rd_s_addr", s_addr, addr);
        next_cycle();
        m0_read = 1'b0; m1_read = 1'b0; s_ready = 1'b0;
    endtask

    task automatic return_beat(input logic [DW-1:0] d);
        int id;
        s_rvalid = 1'b1;
        s_rdata  = d;
        id = rd_id_q.pop_front();
        @(negedge clk);
        check_eq("ret_m0_rvalid", m0_rvalid, (id == 0));
        check_eq("ret_m1_rvalid", m1_rvalid, (id == 1));
        check_eq("ret_rdata", (id == 0) ? m0_rdata : m1_rdata, d);
        next_cycle();
        s_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        // Reset with no requests
        @(negedge clk);
        check_eq("rst_s_read", s_read, 0);
        check_eq("rst_s_write", s_write, 0);
        check_eq("rst_m0_ready", m0_ready, 0);
        check_eq("rst_m1_ready", m1_ready, 0);
        check_eq("rst_rvalid_err", rvalid_err, 0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        check_eq("idle_s_read", s_read, 0);
        check_eq("idle_m0_ready", m0_ready, 0);
        next_cycle();

        // Both masters write continuously: accepts alternate starting with m0
        m0_write = 1'b1; m0_addr = 23'h000100; m0_wdata = 16'h0A0A; m0_byteenable = 2'b01;
        m1_write = 1'b1; m1_addr = 23'h000200; m1_wdata = 16'h0B0B; m1_byteenable = 2'b10;
        s_ready = 1'b1;
        for (int i = 0; i < 6; i++) grant_q.push_back(i % 2);
        repeat (6) begin
            int e;
            e = grant_q.pop_front();
            @(negedge clk);
            check_eq("alt_m0_ready", m0_ready, (e == 0));
            check_eq("alt_m1_ready", m1_ready, (e == 1));
            check_eq("alt_s_addr", s_addr, (e == 1) ? 32'h200 : 32'h100);
            check_eq("alt_s_wdata", s_wdata, (e == 1) ? 32'h0B0B : 32'h0A0A);
            check_eq("alt_s_be", s_byteenable, (e == 1) ? 32'h2 : 32'h1);
            next_cycle();
        end
        clear_inputs();

        // One m0 write so the round-robin pointer favours m1 before the lock test
        m0_write = 1'b1; m0_addr = 23'h000111; s_ready = 1'b1;
        @(negedge clk);
        check_eq("pre_m0_ready", m0_ready, 1);
        next_cycle();
        clear_inputs();

        // Lock: m0 read stalled 3 cycles keeps the grant although m1 now requests
        m0_read = 1'b1; m0_addr = 23'h000010;
        @(negedge clk);
        check_eq("lock_s_read0", s_read, 1);
        check_eq("lock_m0_ready0", m0_ready, 0);
        next_cycle();
        m1_write = 1'b1; m1_addr = 23'h000030;
        repeat (2) begin
            @(negedge clk);
            check_eq("lock_s_read", s_read, 1);
            check_eq("lock_s_write", s_write, 0);
            check_eq("lock_s_addr", s_addr, 32'h10);
            check_eq("lock_m1_ready", m1_ready, 0);
            next_cycle();
        end
        s_ready = 1'b1;
        rd_id_q.push_back(0);
        @(negedge clk);
        check_eq("lock_m0_accept", m0_ready, 1);
        check_eq("lock_m1_wait", m1_ready, 0);
        next_cycle();
        m0_read = 1'b0;
        @(negedge clk);
        check_eq("lock_m1_next", m1_ready, 1);
        check_eq("lock_m1_addr", s_addr, 32'h30);
        next_cycle();
        clear_inputs();
        return_beat(16'h1234);

        // In-order read returns routed to their issuers
        issue_read(1, 23'h000010);
        issue_read(0, 23'h000020);
        issue_read(1, 23'h000030);
        return_beat(16'hAAAA);
        return_beat(16'hBBBB);
        return_beat(16'hCCCC);

        // Fill the tracker, check blocking, writes while full, and release after one return
        for (int i = 0; i < DEPTH; i++) issue_read(0, 23'h000040 + 23'(i));
        m0_read = 1'b1; m0_addr = 23'h000050;
        m1_write = 1'b1; m1_addr = 23'h000060; s_ready = 1'b1;
        @(negedge clk);
        check_eq("full_m0_ready", m0_ready, 0);
        check_eq("full_m1_ready", m1_ready, 1);
        check_eq("full_s_write", s_write, 1);
        check_eq("full_s_read", s_read, 0);
        next_cycle();
        m1_write = 1'b0;
        s_rvalid = 1'b1; s_rdata = 16'h5555;
        begin
            int id;
            id = rd_id_q.pop_front();
            @(negedge clk);
            check_eq("full_pop_rvalid", m0_rvalid, (id == 0));
            check_eq("full_pop_blocked", m0_ready, 0);
        end
        next_cycle();
        s_rvalid = 1'b0;
        rd_id_q.push_back(0);
        @(negedge clk);
        check_eq("unfull_m0_ready", m0_ready, 1);
        check_eq("unfull_s_addr", s_addr, 32'h50);
        next_cycle();
        clear_inputs();
        for (int i = 0; i < DEPTH; i++) return_beat(16'h6000 + 16'(i));

        // Spurious return with nothing outstanding
        s_rvalid = 1'b1; s_rdata = 16'hDEAD;
        @(negedge clk);
        check_eq("err_m0_rvalid", m0_rvalid, 0);
        check_eq("err_m1_rvalid", m1_rvalid, 0);
        next_cycle();
        s_rvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_eq("err_sticky", rvalid_err, 1);
            next_cycle();
        end
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("err_cleared", rvalid_err, 0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Reset with a read outstanding discards it
        issue_read(1, 23'h000070);
        rd_id_q.delete();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        s_rvalid = 1'b1; s_rdata = 16'hBEEF;
        @(negedge clk);
        check_eq("rstmid_m1_rvalid", m1_rvalid, 0);
        next_cycle();
        s_rvalid = 1'b0;
        @(negedge clk);
        check_eq("rstmid_err", rvalid_err, 1);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
